// File: rtl/trisc_mem_pkg.sv
// Shared encodings and defaults for the TRISC memory arbiter.
package trisc_mem_pkg;

   localparam int unsigned AW_DEF     = 5;
   localparam int unsigned DW_DEF     = 8;
   localparam int unsigned RD_LAT_MAX = 4;

   localparam logic GRANT_CPU = 1'b0;
   localparam logic GRANT_LDR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WAIT   = 2'b10,
      ST_DONE   = 2'b11
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; force1 restricts eligibility to requester 1.
module rr_arb2
   import trisc_mem_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   input  logic force1,
   output logic gnt,
   output logic valid
);

   always_comb begin
      gnt   = GRANT_CPU;
      valid = 1'b0;
      if (force1) begin
         gnt   = GRANT_LDR;
         valid = req1;
      end else if (req0 && req1) begin
         gnt   = (last == GRANT_CPU) ? GRANT_LDR : GRANT_CPU;
         valid = 1'b1;
      end else begin
         gnt   = req1 ? GRANT_LDR : GRANT_CPU;
         valid = req0 | req1;
      end
   end

endmodule

// File: rtl/trisc_mem_arbiter.sv
// Shares the single-port TRISC memory between the CPU controller and the loader:
// latches the granted request, drives strobes, times the read and pulses ack.
module trisc_mem_arbiter
   import trisc_mem_pkg::*;
#(
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned DW     = DW_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          clk,
   input  logic          CLR,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_ack,
   output logic [DW-1:0] ldr_rdata,
   input  logic          ldr_mode,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          grant_id
);

   localparam int unsigned CW = $clog2(RD_LAT_MAX);

   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("trisc_mem_arbiter: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
   end

   arb_state_t    state;
   logic          last_grant;
   logic          we_q;
   logic [CW-1:0] cnt;

   logic          arb_gnt;
   logic          arb_valid;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req0   (cpu_req),
      .req1   (ldr_req),
      .last   (last_grant),
      .force1 (ldr_mode),
      .gnt    (arb_gnt),
      .valid  (arb_valid)
   );

   // Request payload of whichever side the arbiter picks this cycle.
   always_comb begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (arb_gnt == GRANT_LDR) begin
         sel_we    = ldr_we;
         sel_addr  = ldr_addr;
         sel_wdata = ldr_wdata;
      end
   end

   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         state      <= ST_IDLE;
         last_grant <= GRANT_LDR;
         we_q       <= 1'b0;
         cnt        <= '0;
         cpu_ack    <= 1'b0;
         ldr_ack    <= 1'b0;
         cpu_rdata  <= '0;
         ldr_rdata  <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= GRANT_CPU;
      end else begin
         cpu_ack <= 1'b0;
         ldr_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  state      <= ST_ACCESS;
                  busy       <= 1'b1;
                  grant_id   <= arb_gnt;
                  last_grant <= arb_gnt;
                  we_q       <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_we     <= sel_we;
                  mem_re     <= ~sel_we;
               end
            end
            ST_ACCESS: begin
               mem_we <= 1'b0;
               mem_re <= 1'b0;
               if (we_q) begin
                  state <= ST_DONE;
                  if (grant_id == GRANT_CPU) cpu_ack <= 1'b1;
                  else                       ldr_ack <= 1'b1;
               end else begin
                  state <= ST_WAIT;
                  cnt   <= CW'(RD_LAT - 1);
               end
            end
            ST_WAIT: begin
               // Last wait cycle: read data is valid now, capture for the owner only.
               if (cnt == '0) begin
                  state <= ST_DONE;
                  if (grant_id == GRANT_CPU) begin
                     cpu_rdata <= mem_rdata;
                     cpu_ack   <= 1'b1;
                  end else begin
                     ldr_rdata <= mem_rdata;
                     ldr_ack   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Scoreboard bench for trisc_mem_arbiter with a RD_LAT-cycle memory model.
module tb_trisc_mem_arbiter;

   localparam int unsigned AW     = 5;
   localparam int unsigned DW     = 8;
   localparam int unsigned RD_LAT = 2;

   logic          clk = 1'b0;
   logic          CLR;
   logic          cpu_req, cpu_we, cpu_ack;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          ldr_req, ldr_we, ldr_ack, ldr_mode;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata, ldr_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we, mem_re, busy, grant_id;

   trisc_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .CLR(CLR),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_mode(ldr_mode),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Memory model: synchronous write, read data appears RD_LAT cycles after mem_re.
   logic [DW-1:0] mem [32];
   logic [DW-1:0] pipe [RD_LAT];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      pipe[0] <= mem_re ? mem[mem_addr] : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_rdata = pipe[RD_LAT-1];

   typedef struct {
      logic          port;
      logic          is_read;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_cpu_ack = 0;
   int   n_ldr_ack = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic is_read, input logic [DW-1:0] rd);
      exp_t e;
      e.port = port; e.is_read = is_read; e.rdata = rd;
      sbq.push_back(e);
   endtask

   // Monitor: pops one expectation per ack and checks strobe/ack exclusivity every cycle.
   always @(negedge clk) begin
      if (!CLR) begin
         chk("strobe_excl", 32'(mem_we & mem_re), 32'd0);
         chk("strobe_outside_busy", 32'((mem_we | mem_re) & ~busy), 32'd0);
         chk("ack_overlap", 32'(cpu_ack & ldr_ack), 32'd0);
         if (cpu_ack ^ ldr_ack) begin
            exp_t e;
            if (cpu_ack) n_cpu_ack++; else n_ldr_ack++;
            if (sbq.size() == 0) begin
               chk("unexpected_ack_port", 32'(ldr_ack), 32'hFFFF);
            end else begin
               e = sbq.pop_front();
               chk("ack_port", 32'(ldr_ack), 32'(e.port));
               if (e.is_read)
                  chk("ack_rdata", 32'(ldr_ack ? ldr_rdata : cpu_rdata), 32'(e.rdata));
            end
         end
      end
   end

   task automatic do_txn(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
      logic got;
      push(port, ~we, rd);
      if (port) begin
         ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
      end else begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         step();
         if (port ? ldr_ack : cpu_ack) got = 1'b1;
      end
      chk("txn_timeout", 32'(got), 32'd1);
      if (port) ldr_req = 1'b0; else cpu_req = 1'b0;
   endtask

   initial begin
      int nc, nl, cpu_before;
      logic got;
      CLR = 1'b1; ldr_mode = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      step(); step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_rdata", 32'({cpu_rdata, ldr_rdata}), 32'd0);
      chk("rst_mem_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
      chk("rst_acks", 32'({cpu_ack, ldr_ack, grant_id}), 32'd0);
      CLR = 1'b0;
      step();

      // 1: CPU write latency
      push(1'b0, 1'b0, 8'h00);
      cpu_we = 1; cpu_addr = 5'h03; cpu_wdata = 8'hA5; cpu_req = 1;
      step();
      chk("t1_mem_we", 32'(mem_we), 32'd1);
      chk("t1_mem_re", 32'(mem_re), 32'd0);
      chk("t1_mem_addr", 32'(mem_addr), 32'h03);
      chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
      chk("t1_busy_c1", 32'(busy), 32'd1);
      chk("t1_ack_c1", 32'(cpu_ack), 32'd0);
      step();
      chk("t1_ack_c2", 32'(cpu_ack), 32'd1);
      chk("t1_busy_c2", 32'(busy), 32'd1);
      cpu_req = 0;
      step();
      chk("t1_idle_c3", 32'(busy), 32'd0);

      // 2: loader preloads 3C@07, then CPU read with RD_LAT=2
      do_txn(1'b1, 1'b1, 5'h07, 8'h3C, 8'h00);
      step();
      push(1'b0, 1'b1, 8'h3C);
      cpu_we = 0; cpu_addr = 5'h07; cpu_req = 1;
      step();
      chk("t2_mem_re", 32'(mem_re), 32'd1);
      chk("t2_mem_we", 32'(mem_we), 32'd0);
      step();
      chk("t2_ack_c2", 32'(cpu_ack), 32'd0);
      step();
      chk("t2_ack_c3", 32'(cpu_ack), 32'd0);
      step();
      chk("t2_ack_c4", 32'(cpu_ack), 32'd1);
      chk("t2_cpu_rdata", 32'(cpu_rdata), 32'h3C);
      chk("t2_ldr_rdata", 32'(ldr_rdata), 32'h00);
      cpu_req = 0;

      // Loader read leaves CPU rdata untouched and makes the loader last granted
      do_txn(1'b1, 1'b0, 5'h07, 8'h00, 8'h3C);
      chk("rd_sep_cpu_rdata", 32'(cpu_rdata), 32'h3C);

      // 3: both hold requests -> CPU, LDR, CPU, LDR
      push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
      push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
      cpu_we = 1; cpu_addr = 5'h10; cpu_wdata = 8'h11;
      ldr_we = 1; ldr_addr = 5'h11; ldr_wdata = 8'h22;
      cpu_req = 1; ldr_req = 1;
      nc = 0; nl = 0;
      for (int i = 0; i < 40 && (nc + nl) < 4; i++) begin
         step();
         if (cpu_ack) nc++;
         if (ldr_ack) nl++;
      end
      cpu_req = 0; ldr_req = 0;
      chk("t3_cpu_acks", 32'(nc), 32'd2);
      chk("t3_ldr_acks", 32'(nl), 32'd2);

      // 4: loader mode locks out a waiting CPU read
      step();
      ldr_mode = 1;
      cpu_we = 0; cpu_addr = 5'h10; cpu_req = 1;
      cpu_before = n_cpu_ack;
      for (int i = 0; i < 4; i++)
         do_txn(1'b1, 1'b1, 5'(i), 8'(i + 1), 8'h00);
      chk("t4_no_cpu_ack", 32'(n_cpu_ack - cpu_before), 32'd0);
      push(1'b0, 1'b1, 8'h11);
      ldr_mode = 0;
      step();
      step();
      chk("t4_cpu_granted", 32'({busy, grant_id}), 32'b10);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (cpu_ack) got = 1'b1;
      end
      chk("t4_cpu_ack_timeout", 32'(got), 32'd1);
      cpu_req = 0;
      do_txn(1'b0, 1'b0, 5'h02, 8'h00, 8'h03);

      // 5: reset during WAIT aborts the read
      step();
      cpu_we = 0; cpu_addr = 5'h03; cpu_req = 1;
      step();
      step();
      CLR = 1;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_strobes", 32'({mem_we, mem_re}), 32'd0);
      chk("t5_mem_addr", 32'(mem_addr), 32'd0);
      chk("t5_rdata", 32'({cpu_rdata, ldr_rdata}), 32'd0);
      chk("t5_ack_gid", 32'({cpu_ack, ldr_ack, grant_id}), 32'd0);
      cpu_req = 0;
      step();
      chk("t5_no_ack_in_clr", 32'({cpu_ack, ldr_ack}), 32'd0);
      step();
      CLR = 0;
      step();
      do_txn(1'b0, 1'b0, 5'h03, 8'h00, 8'h04);

      // 6: CPU drops req during ACCESS of a write
      step();
      push(1'b0, 1'b0, 8'h00);
      cpu_we = 1; cpu_addr = 5'h14; cpu_wdata = 8'h5A; cpu_req = 1;
      step();
      chk("t6_mem_we", 32'(mem_we), 32'd1);
      cpu_req = 0;
      step();
      chk("t6_ack_c2", 32'(cpu_ack), 32'd1);
      step();
      chk("t6_idle", 32'(busy), 32'd0);
      do_txn(1'b0, 1'b0, 5'h14, 8'h00, 8'h5A);

      step(); step();
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
